// File: rtl/multi_data_issuer.sv
// Request/response front end for a data-dependent-latency compute unit: issues one request at a
// time, checks the completion latency, and queues results behind a ready/valid consumer port.
`timescale 1ns / 1ps

module multi_data_issuer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned DEPTH   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              start,
    output logic [DATA_W-1:0] inp,
    input  logic              done,
    input  logic [DATA_W-1:0] out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error,
    output logic              protocol_err
);

    localparam int unsigned PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);
    localparam logic [2:0] DepthC      = 3'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] inp_q, inp_d;
    logic [1:0]        lat_q, lat_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              armed_q, armed_d;
    logic              perr_q, perr_d;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_err;
    logic              pop;

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic              mem_err_q  [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        inp_d     = inp_q;
        lat_d     = lat_q;
        wcnt_d    = wcnt_q;
        armed_d   = armed_q;
        perr_d    = perr_q;
        push      = 1'b0;
        push_data = '0;
        push_err  = 1'b0;
        in_ready  = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low during reset even though the state register already reads idle.
                in_ready = reset_n && (count_q < DepthC);
                if (in_valid && in_ready) begin
                    inp_d   = in_data;
                    lat_d   = in_data[1:0];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                start   = 1'b1;
                wcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (wcnt_q != 4'hF) begin
                    wcnt_d = wcnt_q + 4'd1;
                end
                // wcnt_q counts cycles since start minus one, so on time means wcnt_q == d.
                if (done) begin
                    push      = 1'b1;
                    push_data = out;
                    push_err  = (wcnt_q != {2'b00, lat_q});
                    armed_d   = 1'b1;
                    state_d   = StIdle;
                end else if (wcnt_q >= TimeoutLast) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    armed_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (done && armed_q && (state_q != StWait)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            inp_q   <= '0;
            lat_q   <= '0;
            wcnt_q  <= '0;
            armed_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            lat_q   <= lat_d;
            wcnt_q  <= wcnt_d;
            armed_q <= armed_d;
            perr_q  <= perr_d;
        end
    end

    assign pop          = res_valid && res_ready;
    assign res_valid    = (count_q != 3'd0);
    assign res_data     = mem_data_q[rd_ptr_q];
    assign res_error    = mem_err_q[rd_ptr_q];
    assign inp          = inp_q;
    assign protocol_err = perr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_err_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= push_data;
                mem_err_q[wr_ptr_q]  <= push_err;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_data_issuer.sv
// Bench for multi_data_issuer: a behavioural compute-unit model with a result scoreboard, plus
// directed latency, backpressure, timeout, spurious-done and async-reset scenarios.
`timescale 1ns / 1ps

module tb_multi_data_issuer;

    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 8;
    localparam int unsigned DEP = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } res_t;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          start;
    logic [DW-1:0] inp;
    logic          done;
    logic          model_done;
    logic          spur_done;
    logic [DW-1:0] unit_out;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_error;
    logic          protocol_err;

    int            n_cmp = 0;
    int            n_mis = 0;
    int            n_pop = 0;
    int            unit_lat = 1;   // cycles from start to done; 0 means the unit never answers
    logic [DW-1:0] umask = '0;     // unit result = request payload ^ umask
    int            rr_mode = 0;    // 0: hold off, 1: always ready, 2: random
    int            flush_gen = 0;
    res_t          exp_q[$];

    assign done = model_done | spur_done;

    multi_data_issuer #(
        .DATA_W (DW),
        .TIMEOUT(TO),
        .DEPTH  (DEP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .start       (start),
        .inp         (inp),
        .done        (done),
        .out         (unit_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_error   (res_error),
        .protocol_err(protocol_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Unit model, scoreboard and consumer: pops checked on the falling edge, drive after rising.
    initial begin
        res_t e;
        int   d;
        int   pend;
        int   flush_seen;
        logic [DW-1:0] pend_val;
        model_done = 1'b0;
        unit_out   = '0;
        res_ready  = 1'b0;
        pend       = 0;
        flush_seen = 0;
        pend_val   = '0;
        forever begin
            @(negedge clock);
            if (res_valid && res_ready) begin
                n_pop++;
                check_eq("q_nonempty_at_pop", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("res_data", res_data, e.data);
                    check_eq("res_error", res_error, e.err);
                end
            end
            @(posedge clock);
            #1;
            if (flush_gen != flush_seen) begin
                exp_q.delete();
                flush_seen = flush_gen;
            end
            model_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    model_done = 1'b1;
                    unit_out   = pend_val;
                end
            end
            if (start) begin
                d = int'(inp[1:0]);
                if (unit_lat <= 0 || unit_lat > int'(TO)) begin
                    exp_q.push_back('{data: '0, err: 1'b1});
                end else begin
                    pend     = unit_lat;
                    pend_val = inp ^ umask;
                    exp_q.push_back('{data: pend_val, err: (unit_lat != d + 1)});
                end
            end
            res_ready = (rr_mode == 1) || ((rr_mode == 2) && ($urandom_range(0, 1) == 1));
        end
    end

    task automatic send(input logic [DW-1:0] d, input int lat);
        int guard;
        unit_lat = lat;
        in_data  = d;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check_eq("accept_in_time", guard < 200, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || res_valid) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        check_eq("drain_in_time", guard < 300, 1);
    endtask

    task automatic pulse_done();
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        rr_mode  = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        flush_gen++;
        @(negedge clock);
    endtask

    initial begin
        int n;
        int pop0;
        int sel;
        int lat;
        logic [DW-1:0] dat;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        spur_done = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_start", start, 0);
        check_eq("rst_inp", inp, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_error", res_error, 0);
        check_eq("rst_perr", protocol_err, 0);
        check_eq("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("idle_in_ready", in_ready, 1);

        // Stale done before any transaction completes is tolerated.
        pulse_done();
        check_eq("perr_unarmed", protocol_err, 0);

        // Minimum latency, d=0.
        send(32'h0000_0010, 1);
        check_eq("min_start", start, 1);
        check_eq("min_inp", inp, 32'h0000_0010);
        @(negedge clock);
        check_eq("min_start_low", start, 0);
        check_eq("min_done", done, 1);
        check_eq("min_not_yet_valid", res_valid, 0);
        @(negedge clock);
        check_eq("min_res_valid", res_valid, 1);
        check_eq("min_res_data", res_data, 32'h0000_0010);
        check_eq("min_res_error", res_error, 0);
        rr_mode = 1;
        wait_drain();

        // Maximum latency on time, then an early done.
        send(32'hDEAD_BEEF, 4);
        wait_drain();
        send(32'hDEAD_BEEF, 2);
        wait_drain();

        // Backpressure with the queue full.
        rr_mode = 0;
        send(32'h1, 2);
        send(32'h2, 3);
        repeat (6) @(negedge clock);
        check_eq("bp_full_valid", res_valid, 1);
        in_data  = 32'h3;
        unit_lat = 4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_hold", in_ready, 0);
            @(negedge clock);
        end
        rr_mode = 1;
        @(negedge clock);
        rr_mode = 0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("bp_accept_after_pop", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        rr_mode  = 1;
        wait_drain();

        // Timeout, then a late done.
        send(32'h55, 0);
        check_eq("to_start", start, 1);
        n = 0;
        while (!res_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        check_eq("to_latency", n, TO + 1);
        check_eq("to_res_data", res_data, 0);
        check_eq("to_res_error", res_error, 1);
        check_eq("to_idle", in_ready, 1);
        check_eq("to_perr_before", protocol_err, 0);
        @(negedge clock);
        pulse_done();
        check_eq("to_late_done_perr", protocol_err, 1);

        // Spurious done after a completed transaction.
        do_reset();
        check_eq("perr_cleared", protocol_err, 0);
        rr_mode = 1;
        send(32'h20, 1);
        wait_drain();
        check_eq("sp_perr_before", protocol_err, 0);
        rr_mode = 0;
        pulse_done();
        check_eq("sp_perr", protocol_err, 1);
        check_eq("sp_no_entry", res_valid, 0);
        repeat (5) @(negedge clock);
        check_eq("sp_perr_sticky", protocol_err, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("sp_perr_async_clr", protocol_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        flush_gen++;
        @(negedge clock);

        // Async reset while a request is in flight, with a queued result and protocol_err set.
        rr_mode = 0;
        send(32'h40, 1);
        repeat (3) @(negedge clock);
        check_eq("ar_queued", res_valid, 1);
        pulse_done();
        check_eq("ar_perr_set", protocol_err, 1);
        send(32'h7, 4);
        check_eq("ar_start_before", start, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("ar_start", start, 0);
        check_eq("ar_res_valid", res_valid, 0);
        check_eq("ar_perr", protocol_err, 0);
        check_eq("ar_in_ready", in_ready, 0);
        check_eq("ar_inp", inp, 0);
        @(negedge clock);
        reset_n = 1'b1;
        flush_gen++;
        repeat (8) @(negedge clock);
        check_eq("ar_perr_disarmed", protocol_err, 0);
        check_eq("ar_no_entry", res_valid, 0);

        // Randomized traffic against the scoreboard.
        do_reset();
        rr_mode = 2;
        pop0    = n_pop;
        for (int i = 0; i < 40; i++) begin
            dat   = $urandom;
            umask = $urandom;
            sel   = $urandom_range(0, 3);
            if (sel == 0) begin
                lat = 0;
            end else if (sel == 2) begin
                lat = $urandom_range(1, TO);
            end else begin
                lat = int'(dat[1:0]) + 1;
            end
            send(dat, lat);
        end
        rr_mode = 1;
        wait_drain();
        check_eq("rand_pops", n_pop - pop0, 40);
        check_eq("rand_perr", protocol_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
